// File: rtl/chip8_pkg.sv
// Shared CHIP-8 display geometry and the sprite-draw state encoding.
package chip8_pkg;

    localparam int DISP_W_DEF = 64;
    localparam int DISP_H_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PIXEL,
        DONE
    } draw_state_t;

endpackage

// File: rtl/sprite_draw.sv
// CHIP-8 DXYN engine: fetches N sprite rows and XORs them into the framebuffer one pixel per cycle.
// Define SPRITE_CLIP_EN to skip off-screen pixels instead of wrapping them.
module sprite_draw
    import chip8_pkg::*;
#(
    parameter int DISP_W = DISP_W_DEF,
    parameter int DISP_H = DISP_H_DEF,
    parameter int ADDR_W = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              draw,
    input  logic [7:0]        destx,
    input  logic [7:0]        desty,
    input  logic [3:0]        spriteh,
    input  logic [ADDR_W-1:0] index,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [5:0]        fb_x,
    output logic [4:0]        fb_y,
    input  logic              fb_rdata,
    output logic              fb_we,
    output logic              fb_wdata,
    output logic              busy,
    output logic              drawdone,
    output logic              collision
);

    draw_state_t state, state_next;

    logic [7:0] x0;
    logic [7:0] y0;
    logic [3:0] n_rows;
    logic [3:0] row;
    logic [2:0] col;
    logic [7:0] row_bits;
    logic [8:0] x_sum;
    logic [8:0] y_sum;
    logic       pix_bit;
    logic       pix_off;
    logic       last_col;
    logic       last_row;

    // Origin is already reduced modulo the display, so one subtraction finishes the wrap.
    assign x_sum    = {1'b0, x0} + {6'b0, col};
    assign y_sum    = {1'b0, y0} + {5'b0, row};
    assign fb_x     = (x_sum >= 9'(DISP_W)) ? 6'(x_sum - 9'(DISP_W)) : x_sum[5:0];
    assign fb_y     = (y_sum >= 9'(DISP_H)) ? 5'(y_sum - 9'(DISP_H)) : y_sum[4:0];

    assign pix_bit  = row_bits[7];
    assign last_col = (col == 3'd7);
    assign last_row = (row == n_rows - 4'd1);

`ifdef SPRITE_CLIP_EN
    assign pix_off  = (x_sum >= 9'(DISP_W)) || (y_sum >= 9'(DISP_H));
`else
    assign pix_off  = 1'b0;
`endif

    assign busy     = (state != IDLE);
    assign drawdone = (state == DONE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fb_we      = 1'b0;
        fb_wdata   = 1'b0;
        case (state)
            IDLE: begin
                if (draw) begin
                    state_next = (spriteh == 4'd0) ? DONE : FETCH;
                end
            end
            FETCH: state_next = WAIT;
            WAIT:  state_next = PIXEL;
            PIXEL: begin
                fb_we    = pix_bit & ~pix_off;
                fb_wdata = fb_rdata ^ pix_bit;
                if (last_col) begin
                    state_next = last_row ? DONE : FETCH;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // mem_addr is loaded on the edge into FETCH, so it holds steady in every other state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            x0        <= '0;
            y0        <= '0;
            n_rows    <= '0;
            row       <= '0;
            col       <= '0;
            row_bits  <= '0;
            mem_addr  <= '0;
            collision <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (draw) begin
                        x0        <= 8'(int'(destx) % DISP_W);
                        y0        <= 8'(int'(desty) % DISP_H);
                        n_rows    <= spriteh;
                        row       <= '0;
                        col       <= '0;
                        collision <= 1'b0;
                        if (spriteh != 4'd0) begin
                            mem_addr <= index;
                        end
                    end
                end
                WAIT: begin
                    row_bits <= mem_rdata;
                    col      <= '0;
                end
                PIXEL: begin
                    if (pix_bit && fb_rdata && !pix_off) begin
                        collision <= 1'b1;
                    end
                    row_bits <= {row_bits[6:0], 1'b0};
                    col      <= col + 3'd1;
                    if (last_col && !last_row) begin
                        row      <= row + 4'd1;
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_draw.sv
// Directed bench for sprite_draw: a table of draws checked for latency, fetch address,
// collision, write count and framebuffer image, plus hand-written reset/ignore sequences.
module tb_sprite_draw;

    logic        Clk;
    logic        Reset;
    logic        draw;
    logic [7:0]  destx;
    logic [7:0]  desty;
    logic [3:0]  spriteh;
    logic [11:0] index;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [5:0]  fb_x;
    logic [4:0]  fb_y;
    logic        fb_rdata;
    logic        fb_we;
    logic        fb_wdata;
    logic        busy;
    logic        drawdone;
    logic        collision;

    int n_vectors     = 0;
    int n_miscompares = 0;
    int we_total      = 0;
    int stray_we      = 0;
    int done_total    = 0;

    logic [7:0] smem [0:4095];
    logic fb_mem   [0:31][0:63] = '{default: '0};
    logic model_fb [0:31][0:63] = '{default: '0};

    typedef struct {
        logic [7:0]  dx;
        logic [7:0]  dy;
        logic [3:0]  n;
        logic [11:0] idx;
        int          exp_lat;
        logic        exp_coll;
        int          exp_wr;
    } vec_t;

    vec_t vecs [7];

    sprite_draw dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .draw      (draw),
        .destx     (destx),
        .desty     (desty),
        .spriteh   (spriteh),
        .index     (index),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .fb_x      (fb_x),
        .fb_y      (fb_y),
        .fb_rdata  (fb_rdata),
        .fb_we     (fb_we),
        .fb_wdata  (fb_wdata),
        .busy      (busy),
        .drawdone  (drawdone),
        .collision (collision)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Sprite ROM with one cycle of read latency and a combinational-read framebuffer.
    always @(posedge Clk) begin
        mem_rdata <= smem[mem_addr];
        if (fb_we) fb_mem[fb_y][fb_x] <= fb_wdata;
    end
    assign fb_rdata = fb_mem[fb_y][fb_x];

    always @(negedge Clk) begin
        if (fb_we) we_total <= we_total + 1;
        if (fb_we && !busy) stray_we <= stray_we + 1;
        if (drawdone) done_total <= done_total + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic modelDraw(input logic [7:0] dx, input logic [7:0] dy,
                             input logic [3:0] n, input logic [11:0] idx);
        int x0, y0, xs, ys;
        logic [7:0]  b;
        logic [11:0] a;
        x0 = int'(dx) % 64;
        y0 = int'(dy) % 32;
        for (int r = 0; r < int'(n); r++) begin
            a = idx + 12'(r);
            b = smem[a];
            for (int c = 0; c < 8; c++) begin
                if (b[7-c]) begin
                    xs = x0 + c;
                    ys = y0 + r;
`ifdef SPRITE_CLIP_EN
                    if (xs >= 64 || ys >= 32) continue;
`endif
                    xs = xs % 64;
                    ys = ys % 32;
                    model_fb[ys][xs] = ~model_fb[ys][xs];
                end
            end
        end
    endtask

    function automatic int fbMismatches();
        int cnt = 0;
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 64; x++)
                if (fb_mem[y][x] !== model_fb[y][x]) cnt++;
        return cnt;
    endfunction

    // Issues one draw and reports drawdone latency, mem_addr at T+1, final collision,
    // fb_we count and {drawdone,busy} one cycle after the done pulse.
    task automatic applyStimulus(input logic [7:0] dx, input logic [7:0] dy,
                                 input logic [3:0] n, input logic [11:0] idx,
                                 output int lat, output logic [11:0] addr_t1,
                                 output logic coll, output int wr, output logic [1:0] after);
        int we_start;
        @(negedge Clk);
        destx = dx; desty = dy; spriteh = n; index = idx; draw = 1'b1;
        we_start = we_total;
        @(posedge Clk);
        #1 draw = 1'b0;
        lat = -1;
        addr_t1 = '0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge Clk);
            if (k == 1) addr_t1 = mem_addr;
            if (drawdone) begin
                lat = k;
                break;
            end
        end
        coll = collision;
        wr   = we_total - we_start;
        @(negedge Clk);
        after = {drawdone, busy};
    endtask

    initial begin : main
        int          lat, wr, we_start, busy_cnt, done_start;
        logic [11:0] addr_t1;
        logic        coll;
        logic [1:0]  after;

        for (int i = 0; i < 4096; i++) smem[i] = 8'h00;
        for (int i = 0; i < 5; i++) smem[12'h050 + i] = 8'hF0;
        smem[12'h100] = 8'hFF;
        smem[12'h101] = 8'hFF;
        smem[12'h200] = 8'hA5;
        smem[12'hFFF] = 8'h81;
        smem[12'h000] = 8'h3C;
        for (int i = 0; i < 15; i++) smem[12'h300 + i] = 8'h01;

        vecs[0] = '{8'd0,   8'd0,  4'd5,  12'h050, 51,  1'b0, 20};
        vecs[1] = '{8'd0,   8'd0,  4'd5,  12'h050, 51,  1'b1, 20};
`ifdef SPRITE_CLIP_EN
        vecs[2] = '{8'd62,  8'd31, 4'd2,  12'h100, 21,  1'b0, 2};
`else
        vecs[2] = '{8'd62,  8'd31, 4'd2,  12'h100, 21,  1'b0, 16};
`endif
        vecs[3] = '{8'd200, 8'd40, 4'd1,  12'h200, 11,  1'b0, 4};
        vecs[4] = '{8'd20,  8'd10, 4'd2,  12'hFFF, 21,  1'b0, 6};
        vecs[5] = '{8'd8,   8'd8,  4'd1,  12'h200, 11,  1'b1, 4};
`ifdef SPRITE_CLIP_EN
        vecs[6] = '{8'd56,  8'd20, 4'd15, 12'h300, 151, 1'b1, 12};
`else
        vecs[6] = '{8'd56,  8'd20, 4'd15, 12'h300, 151, 1'b1, 15};
`endif

        Reset = 1'b1; draw = 1'b0; destx = '0; desty = '0; spriteh = '0; index = '0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        checkOutput("reset_busy",      32'(busy),      32'd0);
        checkOutput("reset_drawdone",  32'(drawdone),  32'd0);
        checkOutput("reset_collision", 32'(collision), 32'd0);
        checkOutput("reset_fb_we",     32'(fb_we),     32'd0);
        checkOutput("reset_mem_addr",  32'(mem_addr),  32'd0);
        checkOutput("reset_fb_xy",     32'({fb_x, fb_y}), 32'd0);

        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].dx, vecs[v].dy, vecs[v].n, vecs[v].idx,
                          lat, addr_t1, coll, wr, after);
            modelDraw(vecs[v].dx, vecs[v].dy, vecs[v].n, vecs[v].idx);
            checkOutput($sformatf("v%0d_latency", v),   32'(lat),     32'(vecs[v].exp_lat));
            checkOutput($sformatf("v%0d_fetch_addr", v), 32'(addr_t1), 32'(vecs[v].idx));
            checkOutput($sformatf("v%0d_collision", v), 32'(coll),    32'(vecs[v].exp_coll));
            checkOutput($sformatf("v%0d_writes", v),    32'(wr),      32'(vecs[v].exp_wr));
            checkOutput($sformatf("v%0d_after_done", v), 32'(after),  32'd0);
            checkOutput($sformatf("v%0d_fb_image", v),  32'(fbMismatches()), 32'd0);
        end

        // Zero-height sprite: immediate DONE, no writes, collision cleared, mem_addr untouched.
        applyStimulus(8'd9, 8'd9, 4'd0, 12'h123, lat, addr_t1, coll, wr, after);
        checkOutput("n0_latency",   32'(lat),     32'd1);
        checkOutput("n0_mem_addr",  32'(addr_t1), 32'h30E);
        checkOutput("n0_collision", 32'(coll),    32'd0);
        checkOutput("n0_writes",    32'(wr),      32'd0);
        checkOutput("n0_after",     32'(after),   32'd0);

        // A second draw request at T+5 lands while busy and must be dropped.
        @(negedge Clk);
        destx = 8'd40; desty = 8'd5; spriteh = 4'd1; index = 12'h050; draw = 1'b1;
        we_start = we_total;
        @(posedge Clk);
        #1 draw = 1'b0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge Clk);
            draw = 1'b0;
            if (k == 5) begin
                destx = 8'd0; desty = 8'd0; spriteh = 4'd5; draw = 1'b1;
            end
            if (drawdone) begin
                lat = k;
                break;
            end
        end
        draw = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (busy) busy_cnt++;
        end
        modelDraw(8'd40, 8'd5, 4'd1, 12'h050);
        checkOutput("ignore_latency",   32'(lat),                 32'd11);
        checkOutput("ignore_busy_after", 32'(busy_cnt),           32'd0);
        checkOutput("ignore_writes",    32'(we_total - we_start), 32'd4);
        checkOutput("ignore_collision", 32'(collision),           32'd0);
        checkOutput("ignore_fb_image",  32'(fbMismatches()),      32'd0);

        // Reset wins over a simultaneous draw request.
        @(negedge Clk);
        destx = 8'd1; desty = 8'd1; spriteh = 4'd1; index = 12'h050;
        draw = 1'b1; Reset = 1'b1;
        we_start = we_total;
        @(posedge Clk);
        #1 begin draw = 1'b0; Reset = 1'b0; end
        @(negedge Clk);
        checkOutput("rst_prio_busy", 32'(busy), 32'd0);
        repeat (15) @(negedge Clk);
        checkOutput("rst_prio_writes", 32'(we_total - we_start), 32'd0);

        applyStimulus(8'd30, 8'd15, 4'd3, 12'h050, lat, addr_t1, coll, wr, after);
        modelDraw(8'd30, 8'd15, 4'd3, 12'h050);
        checkOutput("pre_abort_latency", 32'(lat), 32'd31);
        checkOutput("pre_abort_writes",  32'(wr),  32'd12);
        checkOutput("pre_abort_fb",      32'(fbMismatches()), 32'd0);

        // Same sprite again, aborted by Reset in cycle T+23 (row 2, column 0).
        @(negedge Clk);
        destx = 8'd30; desty = 8'd15; spriteh = 4'd3; index = 12'h050; draw = 1'b1;
        @(posedge Clk);
        #1 draw = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            @(negedge Clk);
            if (k == 22) checkOutput("abort_coll_before", 32'(collision), 32'd1);
        end
        Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        we_start   = we_total;
        done_start = done_total;
        checkOutput("abort_busy",      32'(busy),      32'd0);
        checkOutput("abort_collision", 32'(collision), 32'd0);
        checkOutput("abort_fb_we",     32'(fb_we),     32'd0);
        checkOutput("abort_drawdone",  32'(drawdone),  32'd0);
        checkOutput("abort_mem_addr",  32'(mem_addr),  32'd0);
        checkOutput("abort_fb_xy",     32'({fb_x, fb_y}), 32'd0);
        repeat (40) @(negedge Clk);
        checkOutput("abort_writes_after", 32'(we_total - we_start),     32'd0);
        checkOutput("abort_done_after",   32'(done_total - done_start), 32'd0);

        checkOutput("stray_fb_we", 32'(stray_we), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
